rv32i_mem_arbiter: RTL
======================

// Module: rv32i_mem_arbiter
// PURPOSE
//   Shares the single-port memory of the multicycle rv32i core between two requesters:
//   port C (core fetch/load/store) and port A (aux master: program loader / DMA).
//   Owner-tracking FSM with round-robin tie-break and burst limit; 1-cycle read return.
//   Sits between rv32i_multicycle_core's memory interface and the memory model.
// PARAMETERS
//   MAX_BURST  4  max consecutive grants to one owner while the other port requests (>=1)
// PORTS
//   clk          in   1   clock
//   rst          in   1   synchronous, active-high reset
//   c_req        in   1   core requests an access this cycle
//   c_addr       in   32  core address
//   c_wr_data    in   32  core write data
//   c_wr_ena     in   1   core access is a write
//   c_gnt        out  1   core access issued to memory this cycle
//   c_rd_valid   out  1   core read data valid (cycle after read grant)
//   a_req/a_addr/a_wr_data/a_wr_ena/a_gnt/a_rd_valid   same as c_*, for port A
//   rd_data      out  32  mem_rd_data passed through to both ports
//   mem_addr     out  32  to memory
//   mem_wr_data  out  32  to memory
//   mem_wr_ena   out  1   to memory
//   mem_rd_data  in   32  from memory, valid 1 cycle after address
// BEHAVIOUR
//   - Clock/reset: one clock clk; rst is synchronous, active-high.
//   - State: enum {S_IDLE, S_CORE, S_AUX} = current owner; last_owner (1b);
//     burst_cnt ($clog2(MAX_BURST+1) bits, saturating).
//   - Grant is combinational from registered state + this cycle's req; never both gnt high.
//   - S_IDLE: only one req -> grant it; both -> grant port != last_owner; none -> stay.
//   - S_CORE: c_req & (!a_req | burst_cnt < MAX_BURST-1) -> c_gnt; else a_req -> a_gnt;
//     else -> no grant, next S_IDLE. S_AUX symmetric.
//   - On grant: state <= granted owner; last_owner <= granted port; burst_cnt <= same owner
//     as before ? sat(burst_cnt+1) : 0. On no grant: burst_cnt <= 0.
//   - Memory mux: mem_addr/mem_wr_data from granted port; mem_wr_ena = gnt & port wr_ena.
//     No grant: mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
//   - X_rd_valid <= X_gnt & !X_wr_ena (registered); rd_data = mem_rd_data.
//   - A requester keeps req/addr/data stable until its gnt; a write completes at gnt.
//   - Reset values: state=S_IDLE, last_owner=A (core wins first tie), burst_cnt=0,
//     c_rd_valid=a_rd_valid=0; all gnt/mem_* outputs 0 while rst high, regardless of req.
//   - Reset mid-access: pending rd_valid dropped; no retry; requester reissues.
//   - MAX_BURST=1: strict alternation whenever both request.
//   - burst_cnt saturates at MAX_BURST-1; never wraps.
// CONFIGURATION
//   ARB_LOCK_EN defined: adds input a_lock (1b). While state=S_AUX and a_lock=1 and a_req=1,
//     port A keeps the grant regardless of burst_cnt (atomic load/store sequence); c stalls.
//     a_lock ignored in S_IDLE/S_CORE. burst_cnt still counts, saturating.
//   ARB_LOCK_EN undefined: no a_lock port; burst limit always enforced.
// TESTING
//   1 rst=1 with c_req=a_req=1 -> c_gnt=a_gnt=0, mem_wr_ena=0, rd_valid=0; then rst=0.
//   2 c_req read addr 0x10, mem[0x10]=0xDEADBEEF -> c_gnt same cycle, mem_addr=0x10;
//     next cycle c_rd_valid=1, rd_data=0xDEADBEEF, a_rd_valid=0.
//   3 MAX_BURST=4, c_req=a_req=1 held 12 cycles from reset -> grants C,C,C,C,A,A,A,A,C,C,C,C.
//   4 a_req write 0x55 to 0x20 while c idle -> a_gnt=1, mem_wr_ena=1, mem_addr=0x20;
//     a_rd_valid stays 0; subsequent C read of 0x20 returns 0x55.
//   5 ARB_LOCK_EN: A owns, a_lock=1, both req 10 cycles -> a_gnt all 10, c_gnt=0;
//     a_lock=0 -> C granted within 1 cycle (burst_cnt saturated).
//   6 rst asserted cycle after C read grant -> c_rd_valid=0 next cycle, state=S_IDLE;
//     after release both req -> C granted first.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Requester-side memory port shared by the core and the aux master.
// The requester drives req/addr/data; the arbiter returns gnt/rd_valid/rd_data.
interface rv32i_mem_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    logic        gnt;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output req, addr, wr_data, wr_ena,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, addr, wr_data, wr_ena,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-port arbiter (core C / aux A) in front of single-port memory.
// Define ARB_LOCK_EN to add a_lock, which pins the grant on port A.
module rv32i_mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_mem_arbiter_if.slave  c_if,
    rv32i_mem_arbiter_if.slave  a_if,
`ifdef ARB_LOCK_EN
    input  logic                a_lock,
`endif
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    input  logic [31:0]         mem_rd_data
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_CORE, S_AUX} state_e;

    state_e        state_q, state_d;
    logic          last_aux_q, last_aux_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          c_rd_valid_q, c_rd_valid_d;
    logic          a_rd_valid_q, a_rd_valid_d;
    logic          c_gnt, a_gnt;
    logic          a_hold;

`ifdef ARB_LOCK_EN
    assign a_hold = a_lock;
`else
    assign a_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_aux_q   <= 1'b1;
            burst_cnt_q  <= '0;
            c_rd_valid_q <= 1'b0;
            a_rd_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_aux_q   <= last_aux_d;
            burst_cnt_q  <= burst_cnt_d;
            c_rd_valid_q <= c_rd_valid_d;
            a_rd_valid_q <= a_rd_valid_d;
        end
    end

    // Grants are suppressed during reset so no access leaks to memory.
    always_comb begin
        c_gnt = 1'b0;
        a_gnt = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (c_if.req && a_if.req) begin
                        c_gnt = last_aux_q;
                        a_gnt = !last_aux_q;
                    end else begin
                        c_gnt = c_if.req;
                        a_gnt = a_if.req;
                    end
                end
                S_CORE: begin
                    if (c_if.req &&
                        (!a_if.req || burst_cnt_q < CNT_MAX))
                        c_gnt = 1'b1;
                    else
                        a_gnt = a_if.req;
                end
                S_AUX: begin
                    if (a_if.req &&
                        (!c_if.req || burst_cnt_q < CNT_MAX ||
                         a_hold))
                        a_gnt = 1'b1;
                    else
                        c_gnt = c_if.req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        last_aux_d   = last_aux_q;
        burst_cnt_d  = '0;
        c_rd_valid_d = c_gnt && !c_if.wr_ena;
        a_rd_valid_d = a_gnt && !a_if.wr_ena;
        if (c_gnt) begin
            state_d    = S_CORE;
            last_aux_d = 1'b0;
            if (state_q == S_CORE)
                burst_cnt_d = (burst_cnt_q == CNT_MAX) ?
                              CNT_MAX : burst_cnt_q + CW'(1);
        end else if (a_gnt) begin
            state_d    = S_AUX;
            last_aux_d = 1'b1;
            if (state_q == S_AUX)
                burst_cnt_d = (burst_cnt_q == CNT_MAX) ?
                              CNT_MAX : burst_cnt_q + CW'(1);
        end else begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        if (c_gnt) begin
            mem_addr    = c_if.addr;
            mem_wr_data = c_if.wr_data;
            mem_wr_ena  = c_if.wr_ena;
        end else if (a_gnt) begin
            mem_addr    = a_if.addr;
            mem_wr_data = a_if.wr_data;
            mem_wr_ena  = a_if.wr_ena;
        end
    end

    assign c_if.gnt      = c_gnt;
    assign a_if.gnt      = a_gnt;
    assign c_if.rd_valid = c_rd_valid_q;
    assign a_if.rd_valid = a_rd_valid_q;
    assign c_if.rd_data  = mem_rd_data;
    assign a_if.rd_data  = mem_rd_data;

endmodule
